coin_dispenser: RTL
===================

Name: coin_dispenser

Overview:
Payout side of the vending coin interface. The existing machine consumes nickel/dime pulses; this block produces them to return change.
- Accepts a change request in cents.
- Tracks on-board dime and nickel inventory.
- Plans the payout greedily, dimes first with nickel fallback.
- Emits one-cycle nickel/dime pulses with a mechanical recovery gap.
- Reports done or error; nothing is paid on error.

Parameters:
AMT_W, 8, width of requested amount in cents.
CNT_W, 8, width of each coin inventory counter.
GAP, 1, idle cycles after every coin pulse (0 allowed).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low: asserted when 0, released when 1.
req_valid  in  1  change request present.
req_ready  out  1  block idle, can accept a request.
req_amount  in  AMT_W  change amount in cents.
load_dimes  in  1  add load_count to dime inventory this cycle.
load_nickels  in  1  add load_count to nickel inventory this cycle.
load_count  in  CNT_W  refill quantity.
nickel  out  1  one-cycle pulse, eject one nickel.
dime  out  1  one-cycle pulse, eject one dime.
busy  out  1  high whenever state is not IDLE.
done  out  1  one-cycle pulse, payout complete.
error  out  1  one-cycle pulse, request rejected.
dimes_left  out  CNT_W  current dime inventory.
nickels_left  out  CNT_W  current nickel inventory.

Behaviour:
Reset:
- All outputs are 0.
- Inventories are 0.
- State is IDLE.
- req_ready rises on the first clock after reset is released.
- Reset asserted mid-payout aborts immediately; no further pulses.

States: IDLE, CHECK, DIME, NICKEL, WAIT, FIN, ERR.
- req_ready = (state == IDLE).
- Accept on req_valid & req_ready at edge t; req_amount is latched.
- CHECK (cycle t+1) computes the plan from an inventory snapshot:
  - n = amount/5; d = min(dimes_left, n/2); k = n - 2d.
  - amount % 5 != 0 -> ERR.
  - k > nickels_left -> ERR.
  - n == 0 -> FIN.
  - Otherwise -> DIME if d > 0, else NICKEL.
- DIME / NICKEL:
  - Assert the corresponding pulse for exactly one cycle.
  - Decrement the remaining plan count and the matching inventory.
  - Then go to WAIT for GAP cycles, or directly to the next coin state if GAP = 0.
- Ordering: all d dimes are paid before any nickels. Once both plan counts reach 0, go to FIN.
- FIN: done = 1 for one cycle, then IDLE.
- ERR: error = 1 for one cycle, then IDLE. No pulses issued; inventory unchanged.
- nickel and dime are never high in the same cycle.
- First pulse appears at t+2. done/error also appear at t+2 for the zero-amount and reject cases.

Inventory update (per counter, every cycle, any state):
- next = cnt + (load ? load_count : 0) - (pulse ? 1 : 0).
- Saturate at 2^CNT_W-1.
- Simultaneous load and decrement apply both (net).
- A refill during a payout does not alter the plan fixed in CHECK.
- Both loads in the same cycle add load_count to each counter.

req_valid while busy is ignored (no ready).

Decomposition:
- Package coin_pkg: state enum; NICKEL_CENTS = 5, DIME_CENTS = 10.
- Sub-module coin_inventory (CNT_W): saturating up/down counter with load and decrement inputs, async active-low reset. Instantiated twice, once for dimes and once for nickels.
- The FSM and plan arithmetic live in coin_dispenser.

Test Plan:
- Exact payout: GAP = 1; load 3 dimes, 4 nickels; request 35 at t.
  - dime pulses at t+2, t+4, t+6; nickel at t+8; done at t+10; req_ready at t+11.
  - Final inventory: 0 dimes, 3 nickels.
- Fallback and reject: 1 dime, 5 nickels.
  - Request 30 -> 1 dime then 4 nickels, done; inventory 0/1.
  - Fresh 1/5, request 40 -> error at t+2, zero pulses, inventory stays 1/5.
- Bad/zero amounts:
  - Request 12 -> error at t+2, no pulses.
  - Request 0 -> done at t+2, no pulses.
  - Both return to ready next cycle.
- Refill overlap and saturation, CNT_W = 8:
  - load_dimes with 5 on the same cycle as a dime pulse (from 3) -> dimes_left = 7.
  - load_nickels 250 twice -> nickels_left = 255.
- Reset mid-payout: assert reset low after the 2nd of 4 pulses.
  - Outputs go 0 immediately, inventory 0, no further pulses, no done.
  - req_ready = 1 on the first edge after release.
- Handshake: hold req_valid high through a payout.
  - Exactly one request accepted per IDLE cycle.
  - Back-to-back requests: a new CHECK begins the cycle after req_ready.

Source files
------------

// File: rtl/coin_pkg.sv
// Shared types and constants for the coin payout block.
// Holds the payout state encoding and the next-coin selection helper.
package coin_pkg;

  localparam int NICKEL_CENTS = 5;
  localparam int DIME_CENTS   = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_DIME,
    S_NICKEL,
    S_WAIT,
    S_FIN,
    S_ERR
  } state_t;

  // Dimes always drain before nickels; FIN once both plan counts are empty.
  function automatic state_t next_coin(input logic dimes_pending,
                                       input logic nickels_pending);
    if (dimes_pending) return S_DIME;
    if (nickels_pending) return S_NICKEL;
    return S_FIN;
  endfunction

endpackage

// File: rtl/coin_inventory.sv
// Saturating coin counter: adds a refill and removes one ejected coin per cycle.
// A refill and an ejection in the same cycle are both applied.
module coin_inventory #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_count,
  input  logic             dec,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W:0] MAX_CNT = {1'b0, {CNT_W{1'b1}}};

  logic [CNT_W:0] sum;
  logic [CNT_W:0] net;

  always_comb begin
    sum = {1'b0, count} + (load ? {1'b0, load_count} : '0);
    net = sum;
    if (dec && (sum != '0)) net = sum - 1'b1;
    if (net > MAX_CNT) net = MAX_CNT;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count <= '0;
    else        count <= net[CNT_W-1:0];
  end

endmodule

// File: rtl/coin_dispenser.sv
// Change payout controller: plans a greedy dime/nickel payout from inventory
// and emits one coin pulse per coin with a recovery gap between pulses.
module coin_dispenser
  import coin_pkg::*;
#(
  parameter int AMT_W = 8,
  parameter int CNT_W = 8,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AMT_W-1:0] req_amount,
  input  logic             load_dimes,
  input  logic             load_nickels,
  input  logic [CNT_W-1:0] load_count,
  output logic             nickel,
  output logic             dime,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] dimes_left,
  output logic [CNT_W-1:0] nickels_left,
  output state_t           dbg_state
);

  localparam int PW = ((AMT_W > CNT_W) ? AMT_W : CNT_W) + 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  state_t           state, state_n;
  logic [AMT_W-1:0] amt_q, amt_n;
  logic [AMT_W-1:0] d_rem, d_n;
  logic [AMT_W-1:0] k_rem, k_n;
  logic [GW-1:0]    gap_cnt, gap_n;
  logic             started;

  logic [AMT_W-1:0] n_c, rem_c;
  logic [PW-1:0]    half_w, dl_w, d_w, k_w, nl_w;

  // Plan from the inventory snapshot seen during CHECK; 2*d <= n so k never wraps.
  always_comb begin
    n_c    = amt_q / AMT_W'(NICKEL_CENTS);
    rem_c  = amt_q % AMT_W'(NICKEL_CENTS);
    half_w = PW'(n_c >> 1);
    dl_w   = PW'(dimes_left);
    nl_w   = PW'(nickels_left);
    d_w    = (dl_w < half_w) ? dl_w : half_w;
    k_w    = PW'(n_c) - (d_w << 1);
  end

  // Request handshake: a request transfers on a rising edge where req_valid
  // and req_ready are both high; req_amount is captured on that edge only.
  always_comb begin
    state_n = state;
    amt_n   = amt_q;
    d_n     = d_rem;
    k_n     = k_rem;
    gap_n   = gap_cnt;
    unique case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          amt_n   = req_amount;
          state_n = S_CHECK;
        end
      end
      S_CHECK: begin
        if (rem_c != '0)       state_n = S_ERR;
        else if (k_w > nl_w)   state_n = S_ERR;
        else if (n_c == '0)    state_n = S_FIN;
        else begin
          d_n     = AMT_W'(d_w);
          k_n     = AMT_W'(k_w);
          state_n = (d_w != '0) ? S_DIME : S_NICKEL;
        end
      end
      S_DIME: begin
        d_n = d_rem - AMT_W'(1);
        if (GAP == 0) state_n = next_coin(d_n != '0, k_rem != '0);
        else begin
          gap_n   = GW'((GAP > 0) ? GAP - 1 : 0);
          state_n = S_WAIT;
        end
      end
      S_NICKEL: begin
        k_n = k_rem - AMT_W'(1);
        if (GAP == 0) state_n = next_coin(d_rem != '0, k_n != '0);
        else begin
          gap_n   = GW'((GAP > 0) ? GAP - 1 : 0);
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (gap_cnt == '0) state_n = next_coin(d_rem != '0, k_rem != '0);
        else               gap_n   = gap_cnt - GW'(1);
      end
      S_FIN:   state_n = S_IDLE;
      S_ERR:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      amt_q   <= '0;
      d_rem   <= '0;
      k_rem   <= '0;
      gap_cnt <= '0;
      started <= 1'b0;
    end else begin
      state   <= state_n;
      amt_q   <= amt_n;
      d_rem   <= d_n;
      k_rem   <= k_n;
      gap_cnt <= gap_n;
      started <= 1'b1;
    end
  end

  // started keeps req_ready low until the first edge after reset release.
  assign req_ready = started && (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign dime      = (state == S_DIME);
  assign nickel    = (state == S_NICKEL);
  assign done      = (state == S_FIN);
  assign error     = (state == S_ERR);
  assign dbg_state = state;

  coin_inventory #(.CNT_W(CNT_W)) u_dimes (
    .clk        (clk),
    .reset      (reset),
    .load       (load_dimes),
    .load_count (load_count),
    .dec        (dime),
    .count      (dimes_left)
  );

  coin_inventory #(.CNT_W(CNT_W)) u_nickels (
    .clk        (clk),
    .reset      (reset),
    .load       (load_nickels),
    .load_count (load_count),
    .dec        (nickel),
    .count      (nickels_left)
  );

endmodule
